// File: rtl/rv32i_types.sv
// Shared RV32 type package.
// Provides the M-extension funct3 encoding used by the multiply/divide
// sequencer and the architecturally defined results for the divide
// special cases (divide by zero and signed overflow).
package rv32i_types;

    // funct3 encoding of the RV32M instructions
    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } muldiv_ops;

    // Quotient returned for a divide by zero
    localparam logic [31:0] MULDIV_DIV0_Q = 32'hFFFF_FFFF;
    // Quotient returned for signed overflow (most negative / -1)
    localparam logic [31:0] MULDIV_OVF_Q  = 32'h8000_0000;

    // div/divu/rem/remu all have funct3[2] set
    function automatic logic is_div_op(input muldiv_ops op);
        return op[2];
    endfunction

    // rem/remu have funct3[1] set within the divide group
    function automatic logic is_rem_op(input muldiv_ops op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result interface between the EX-stage control unit and the
// iterative multiply/divide sequencer.
//   start  : issue request (control -> sequencer)
//   op     : RV32M funct3
//   a, b   : rs1 / rs2 operands
//   flush  : abort any in-flight operation
//   busy   : sequencer is working, stall the pipeline
//   done   : one-cycle pulse, result valid
//   result : 32-bit result, held until the next operation completes
interface muldiv_seq_if;
    import rv32i_types::*;

    logic        start;
    muldiv_ops   op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction and result select for the sequencer.
// Ports:
//   op     : operation being finished
//   acc    : 64-bit datapath value; product for multiplies,
//            {remainder, quotient} of the magnitudes for divides
//   neg_a  : dividend / multiplicand was treated as negative
//   neg_b  : divisor / multiplier was treated as negative
//   result : signed-corrected 32-bit result
module muldiv_sign_fix
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_ops              op,
    input  logic [2*WIDTH-1:0]     acc,
    input  logic                   neg_a,
    input  logic                   neg_b,
    output logic [WIDTH-1:0]       result
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // NOTE: every output of an always_comb gets a value on every path
    // (here unconditionally, then via a case with a default) so no latch
    // is inferred.
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        // The remainder follows the sign of the dividend only
        rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        case (op)
            MULDIV_MUL:                              result = prod[WIDTH-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result = prod[2*WIDTH-1:WIDTH];
            MULDIV_DIV, MULDIV_DIVU:                 result = quot;
            default:                                 result = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// A radix-2 shift-add multiplier / restoring divider runs on operand
// magnitudes for 32 iterations; signs are fixed up on the way out.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_seq_if slave (start/op/a/b/flush in, busy/done/result out)
module muldiv_seq
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t S_IDLE = 2'd0;
    localparam muldiv_state_t S_PREP = 2'd1;
    localparam muldiv_state_t S_CALC = 2'd2;
    localparam muldiv_state_t S_DONE = 2'd3;

    muldiv_state_t        state;
    muldiv_ops            op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     result_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg_a;
    logic                 neg_b;

    // PREP-cycle decode of the latched operands
    logic                 sgn_a;
    logic                 sgn_b;
    logic [WIDTH-1:0]     mag_a_c;
    logic [WIDTH-1:0]     mag_b_c;
    logic                 special;
    logic [WIDTH-1:0]     special_q;

    // One CALC iteration
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     fix_result;

    always_comb begin
        sgn_a = (op_q inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM})
                & a_q[WIDTH-1];
        sgn_b = (op_q inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM})
                & b_q[WIDTH-1];
        mag_a_c = sgn_a ? -a_q : a_q;
        mag_b_c = sgn_b ? -b_q : b_q;

        special   = 1'b0;
        special_q = '0;
        if (is_div_op(op_q) && (b_q == '0)) begin
            special   = 1'b1;
            special_q = is_rem_op(op_q) ? a_q : MULDIV_DIV0_Q;
        end else if ((op_q == MULDIV_DIV || op_q == MULDIV_REM) &&
                     (a_q == MULDIV_OVF_Q) && (b_q == '1)) begin
            special   = 1'b1;
            special_q = is_rem_op(op_q) ? '0 : MULDIV_OVF_Q;
        end
    end

    always_comb begin
        // Multiply: add the multiplicand into the high half when the
        // multiplier LSB (held in the low half) is set, then shift right.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};

        // Divide: shift {rem,quot} left by one; the extra top bit keeps
        // the shifted remainder from overflowing before the trial subtract.
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, mag_b});
        rem_new = rem_ge ? (rem_sh[WIDTH-1:0] - mag_b) : rem_sh[WIDTH-1:0];

        if (is_div_op(op_q)) begin
            acc_next = {rem_new, acc[WIDTH-2:0], rem_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix sees the post-iteration value so the final CALC cycle can
    // register the finished result directly.
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op     (op_q),
        .acc    (acc_next),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .result (fix_result)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: every register is in the async reset, including operands and
    // datapath, so no stale value from an aborted op can leak into the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= MULDIV_MUL;
            a_q      <= '0;
            b_q      <= '0;
            mag_b    <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_PREP: begin
                    neg_a <= sgn_a;
                    neg_b <= sgn_b;
                    mag_b <= mag_b_c;
                    acc   <= {{WIDTH{1'b0}}, mag_a_c};
                    cnt   <= CW'(WIDTH - 1);
                    if (special) begin
                        result_q <= special_q;
                        state    <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= fix_result;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation
                    if (bus.start) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        state <= S_PREP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = (state == S_PREP) || (state == S_CALC);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: an arithmetic reference model with a
// cycle-latency model, a per-cycle compare process, directed literal
// cases and randomized operations.
module tb_muldiv_seq;
    import rv32i_types::*;

    logic clk;
    logic rst_n;
    muldiv_seq_if bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Cycle model: m_k counts cycles since the accept edge (cycle 0).
    logic        m_active = 1'b0;
    int          m_k      = 0;
    int          m_lat    = 0;
    logic [31:0] m_exp    = '0;
    logic [31:0] m_result = '0;
    logic        m_busy   = 1'b0;
    logic        m_done   = 1'b0;

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_result = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
    endtask

    // Called right after each rising edge with the inputs sampled at that edge
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (bus.flush) begin
            m_active = 1'b0;
        end else if (bus.start && !m_busy) begin
            m_active = 1'b1;
            m_k      = 1;
            m_lat    = ref_latency(bus.op, bus.a, bus.b);
            m_exp    = ref_result(bus.op, bus.a, bus.b);
        end else if (m_active) begin
            if (m_k == m_lat) m_active = 1'b0;
            else m_k++;
        end
        if (m_active && m_k == m_lat) m_result = m_exp;
        m_busy = m_active && (m_k < m_lat);
        m_done = m_active && (m_k == m_lat);
    endtask

    // Compare process: outputs are checked every cycle on the falling edge
    always @(negedge clk) begin
        check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
        check("done", {31'b0, bus.done}, {31'b0, m_done});
        check("result", bus.result, m_result);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_start(input logic [2:0] opv, input logic [31:0] av, input logic [31:0] bv);
        bus.start = 1'b1;
        bus.op    = muldiv_ops'(opv);
        bus.a     = av;
        bus.b     = bv;
    endtask

    // Issue one op from a falling edge; returns at the falling edge of done
    task automatic run_op(input string name, input logic [2:0] opv, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp, input int lat);
        int k;
        drive_start(opv, av, bv);
        step();
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 60) begin
            step();
            k++;
        end
        check({name, " latency"}, k, lat);
        check({name, " result"}, bus.result, exp);
    endtask

    initial begin
        int k;
        int guard;
        int fl_at;
        logic do_flush;
        logic [2:0]  opv;
        logic [31:0] av, bv;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = MULDIV_MUL;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (2) step();
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed cases, chained so each start lands in the previous DONE cycle
        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        34);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         34);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         32'd5,         2);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);

        // Start while busy in cycle 10 is ignored
        drive_start(3'd0, 32'd6, 32'd7);
        step();
        bus.start = 1'b0;
        k = 1;
        while (k < 10) begin step(); k++; end
        drive_start(3'd5, 32'd1000, 32'd3);
        step();
        bus.start = 1'b0;
        k++;
        while (!bus.done && k < 60) begin step(); k++; end
        check("busy-start latency", k, 34);
        check("busy-start result", bus.result, 32'd42);
        step();

        // Flush in cycle 12: busy drops in cycle 13, result untouched
        drive_start(3'd0, 32'd9, 32'd9);
        step();
        bus.start = 1'b0;
        k = 1;
        while (k < 12) begin step(); k++; end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush busy", {31'b0, bus.busy}, 32'd0);
        check("flush result", bus.result, 32'd42);
        repeat (40) step();
        run_op("after flush", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        step();

        // Reset mid-CALC
        drive_start(3'd5, 32'd500, 32'd3);
        step();
        bus.start = 1'b0;
        repeat (19) step();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset busy", {31'b0, bus.busy}, 32'd0);
        check("midreset done", {31'b0, bus.done}, 32'd0);
        check("midreset result", bus.result, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (40) step();
        run_op("after reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        // Randomized operations, checked cycle by cycle against the model
        for (int n = 0; n < 60; n++) begin
            opv = 3'($urandom_range(0, 7));
            av  = $urandom;
            bv  = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
                2: bv = $urandom_range(1, 15);
                3: av = $urandom_range(0, 255);
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) step();
            do_flush = ($urandom_range(0, 9) == 0);
            fl_at    = $urandom_range(1, 30);
            drive_start(opv, av, bv);
            step();
            bus.start = 1'b0;
            k = 1;
            guard = 0;
            while (m_busy && guard < 60) begin
                if (do_flush && k == fl_at) bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
                k++;
                guard++;
            end
            check("random bounded", {31'b0, (guard < 60)}, 32'd1);
        end
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
